// File: rtl/baccarat_round_fsm.sv
// Baccarat round sequencer: deals four cards, applies the punto banco
// third-card rules, registers the result lights and keeps saturating tallies.
module baccarat_round_fsm #(
  parameter int TALLY_W     = 8,
  parameter int NATURAL_MIN = 8,
  parameter int AUTO_START  = 0
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               start,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic               done,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties,
  output logic [TALLY_W-1:0] rounds
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    P1     = 4'd1,
    D1     = 4'd2,
    P2     = 4'd3,
    D2     = 4'd4,
    EVAL4  = 4'd5,
    P3     = 4'd6,
    EVALB  = 4'd7,
    D3     = 4'd8,
    SETTLE = 4'd9,
    RESULT = 4'd10
  } state_t;

  localparam logic [3:0]         NAT_MIN   = 4'(NATURAL_MIN);
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};
  localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);

  state_t             state_q, state_d;
  logic               banker_draw;
  logic               enter_result;
  logic               load_pcard1_q, load_pcard2_q, load_pcard3_q;
  logic               load_dcard1_q, load_dcard2_q, load_dcard3_q;
  logic               player_light_q, dealer_light_q;
  logic               busy_q, done_q;
  logic [TALLY_W-1:0] player_wins_q, dealer_wins_q, ties_q, rounds_q;

  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
    return (v == TALLY_MAX) ? v : v + TALLY_ONE;
  endfunction

  // Banker third-card decision after the player has drawn.
  always_comb begin
    banker_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (pcard3 != 4'd8);
      4'd4:             banker_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             banker_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             banker_draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  // Next-state function of the round sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start || (AUTO_START != 0)) state_d = P1;
      P1:     state_d = D1;
      D1:     state_d = P2;
      P2:     state_d = D2;
      D2:     state_d = EVAL4;
      EVAL4: begin
        if ((pscore >= NAT_MIN) || (dscore >= NAT_MIN)) state_d = RESULT;
        else if (pscore <= 4'd5)                        state_d = P3;
        else if (dscore <= 4'd5)                        state_d = D3;
        else                                            state_d = RESULT;
      end
      P3:     state_d = EVALB;
      EVALB:  state_d = banker_draw ? D3 : RESULT;
      D3:     state_d = SETTLE;
      SETTLE: state_d = RESULT;
      RESULT: if (start) state_d = P1;
      default: state_d = IDLE;
    endcase
  end

  assign enter_result = (state_d == RESULT) && (state_q != RESULT);

  // State register with every output registered from the next state,
  // so strobes line up exactly with the state they belong to.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q        <= IDLE;
      load_pcard1_q  <= 1'b0;
      load_pcard2_q  <= 1'b0;
      load_pcard3_q  <= 1'b0;
      load_dcard1_q  <= 1'b0;
      load_dcard2_q  <= 1'b0;
      load_dcard3_q  <= 1'b0;
      player_light_q <= 1'b0;
      dealer_light_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      player_wins_q  <= '0;
      dealer_wins_q  <= '0;
      ties_q         <= '0;
      rounds_q       <= '0;
    end else begin
      state_q       <= state_d;
      load_pcard1_q <= (state_d == P1);
      load_dcard1_q <= (state_d == D1);
      load_pcard2_q <= (state_d == P2);
      load_dcard2_q <= (state_d == D2);
      load_pcard3_q <= (state_d == P3);
      load_dcard3_q <= (state_d == D3);
      busy_q        <= (state_d != IDLE) && (state_d != RESULT);
      done_q        <= enter_result;
      if (enter_result) begin
        // Scores presented in the deciding state are final for this round.
        player_light_q <= (pscore >= dscore);
        dealer_light_q <= (dscore >= pscore);
        rounds_q       <= sat_inc(rounds_q);
        if (pscore > dscore)      player_wins_q <= sat_inc(player_wins_q);
        else if (dscore > pscore) dealer_wins_q <= sat_inc(dealer_wins_q);
        else                      ties_q        <= sat_inc(ties_q);
      end else if (state_d == P1) begin
        player_light_q <= 1'b0;
        dealer_light_q <= 1'b0;
      end
    end
  end

  assign load_pcard1      = load_pcard1_q;
  assign load_pcard2      = load_pcard2_q;
  assign load_pcard3      = load_pcard3_q;
  assign load_dcard1      = load_dcard1_q;
  assign load_dcard2      = load_dcard2_q;
  assign load_dcard3      = load_dcard3_q;
  assign player_win_light = player_light_q;
  assign dealer_win_light = dealer_light_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign player_wins      = player_wins_q;
  assign dealer_wins      = dealer_wins_q;
  assign ties             = ties_q;
  assign rounds           = rounds_q;

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// Randomised scoreboard bench for baccarat_round_fsm with a rule-level model.
module tb_baccarat_round_fsm;

  localparam int TW     = 4;
  localparam int NATMIN = 8;
  localparam int SATMAX = 15;

  logic          slow_clock = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    pscore = '0, dscore = '0, pcard3 = '0;
  logic          load_pcard1, load_pcard2, load_pcard3;
  logic          load_dcard1, load_dcard2, load_dcard3;
  logic          player_win_light, dealer_win_light, busy, done;
  logic [TW-1:0] player_wins, dealer_wins, ties, rounds;

  baccarat_round_fsm #(.TALLY_W(TW), .NATURAL_MIN(NATMIN), .AUTO_START(0)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .busy(busy), .done(done),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties), .rounds(rounds)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic [1:0] lights;
    int         pw, dw, ti, ro;
    bit         pdraw, bdraw;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pw = 0, m_dw = 0, m_ti = 0, m_ro = 0;

  // Banker draws when bit [player third card] is set, indexed by banker two-card score.
  logic [9:0] bank_mask [8] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF,
                                10'h0FC, 10'h0F0, 10'h0C0, 10'h000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= SATMAX) ? SATMAX : v + 1;
  endfunction

  // Play the hand by the table rules and push the expected outcome.
  task automatic predict(input int p2, input int d2, input int pc3, input int p3, input int d3);
    exp_t e;
    int fp, fd;
    logic [9:0] m;
    e.pdraw = 0;
    e.bdraw = 0;
    if (p2 >= NATMIN || d2 >= NATMIN) begin
      fp = p2; fd = d2;
    end else if (p2 <= 5) begin
      e.pdraw = 1;
      fp = p3;
      m = bank_mask[d2 & 7];
      e.bdraw = m[pc3];
      fd = e.bdraw ? d3 : d2;
    end else begin
      fp = p2;
      e.bdraw = (d2 <= 5);
      fd = e.bdraw ? d3 : d2;
    end
    e.lat = 6 + 2 * int'(e.pdraw) + 2 * int'(e.bdraw);
    m_ro = sat(m_ro);
    if (fp > fd)      begin e.lights = 2'b10; m_pw = sat(m_pw); end
    else if (fd > fp) begin e.lights = 2'b01; m_dw = sat(m_dw); end
    else              begin e.lights = 2'b11; m_ti = sat(m_ti); end
    e.pw = m_pw; e.dw = m_dw; e.ti = m_ti; e.ro = m_ro;
    sb.push_back(e);
  endtask

  function automatic logic [25:0] all_outs();
    return {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
            player_win_light, dealer_win_light, busy, done,
            player_wins, dealer_wins, ties, rounds};
  endfunction

  task automatic do_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    start  = 1'b0;
    m_pw = 0; m_dw = 0; m_ti = 0; m_ro = 0;
    sb.delete();
    repeat (2) @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);
  endtask

  // Drive one round; react to strobes like the card datapath would.
  task automatic run_round(input int p2, input int d2, input int pc3, input int p3,
                           input int d3, input bit rst_mid);
    bit got_done;
    got_done = 0;
    pscore = 4'(p2);
    dscore = 4'(d2);
    pcard3 = 4'($urandom_range(0, 9));
    predict(p2, d2, pc3, p3, d3);
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    chk("start_to_p1", load_pcard1, 1);
    for (int i = 0; i < 20; i++) begin
      // start is ignored mid-deal, so toggle it where it cannot reach RESULT
      if (load_pcard1 || load_dcard1 || load_pcard2) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (rst_mid && load_pcard2) begin
        resetb = 1'b0;
        start  = 1'b0;
        #1;
        chk("reset_mid_outputs", 32'(all_outs()), 0);
        void'(sb.pop_back());
        m_pw = 0; m_dw = 0; m_ti = 0; m_ro = 0;
        repeat (2) @(negedge slow_clock);
        resetb = 1'b1;
        @(negedge slow_clock);
        return;
      end
      if (load_pcard3) begin pcard3 = 4'(pc3); pscore = 4'(p3); end
      if (load_dcard3) dscore = 4'(d3);
      @(negedge slow_clock);
      if (done) begin got_done = 1; break; end
    end
    start = 1'b0;
    if (!got_done) begin
      chk("round_timeout", 0, 1);
      do_reset();
    end
    repeat ($urandom_range(0, 2)) @(negedge slow_clock);
  endtask

  // Monitor: pops the scoreboard on done and checks per-cycle invariants.
  initial begin
    int lat, h_pw, h_dw, h_ti, h_ro;
    bit in_round, pseen, bseen;
    logic [1:0] hold_l;
    exp_t e;
    lat = 0; h_pw = 0; h_dw = 0; h_ti = 0; h_ro = 0;
    in_round = 0; pseen = 0; bseen = 0; hold_l = 2'b00;
    forever begin
      @(negedge slow_clock);
      if (!resetb) begin
        lat = 0; h_pw = 0; h_dw = 0; h_ti = 0; h_ro = 0;
        in_round = 0; pseen = 0; bseen = 0; hold_l = 2'b00;
      end else begin
        chk("strobe_onehot", 32'($countones({load_pcard1, load_pcard2, load_pcard3,
                                              load_dcard1, load_dcard2, load_dcard3}) <= 1), 1);
        if (load_pcard1) begin in_round = 1; lat = 0; pseen = 0; bseen = 0; hold_l = 2'b00; end
        if (in_round) lat++;
        if (load_pcard3) pseen = 1;
        if (load_dcard3) bseen = 1;
        if (done) begin
          in_round = 0;
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("lights", {player_win_light, dealer_win_light}, e.lights);
            chk("player_wins", player_wins, e.pw);
            chk("dealer_wins", dealer_wins, e.dw);
            chk("ties", ties, e.ti);
            chk("rounds", rounds, e.ro);
            chk("player_drew", pseen, e.pdraw);
            chk("banker_drew", bseen, e.bdraw);
            chk("latency", lat, e.lat);
            hold_l = e.lights;
            h_pw = e.pw; h_dw = e.dw; h_ti = e.ti; h_ro = e.ro;
          end
        end else begin
          chk("hold_player_wins", player_wins, h_pw);
          chk("hold_dealer_wins", dealer_wins, h_dw);
          chk("hold_ties", ties, h_ti);
          chk("hold_rounds", rounds, h_ro);
          if (!in_round) chk("lights_hold", {player_win_light, dealer_win_light}, hold_l);
          else           chk("lights_clear", {player_win_light, dealer_win_light}, 0);
        end
        chk("busy", busy, in_round);
      end
    end
  end

  // Stimulus: directed hands, banker-table sweep, saturation, random play.
  initial begin
    repeat (3) @(negedge slow_clock);
    chk("reset_state", 32'(all_outs()), 0);
    resetb = 1'b1;
    repeat (3) @(negedge slow_clock);
    chk("idle_without_start", 32'(all_outs()), 0);

    run_round(6, 9, 0, 0, 0, 0);   // banker natural
    run_round(9, 9, 0, 0, 0, 0);   // tied naturals
    run_round(8, 8, 0, 0, 0, 0);   // tied eights
    run_round(4, 3, 8, 5, 0, 0);   // player draws an 8, banker stands on 3
    run_round(4, 3, 7, 1, 6, 0);   // player draws a 7, banker draws
    run_round(7, 4, 0, 0, 2, 0);   // player stands, banker draws directly
    run_round(7, 4, 0, 0, 2, 1);   // reset during the second player card

    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 10; c++)
        run_round($urandom_range(0, 5), d, c, $urandom_range(0, 9), $urandom_range(0, 9), 0);

    do_reset();
    for (int i = 0; i < 17; i++) run_round(9, 0, 0, 0, 0, 0);
    chk("sat_player_wins", player_wins, 15);
    chk("sat_rounds", rounds, 15);

    do_reset();
    for (int i = 0; i < 120; i++)
      run_round($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 9), $urandom_range(0, 9), ($urandom_range(0, 9) == 0));

    repeat (2) @(negedge slow_clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
